// File: rtl/ibex_cpi_sample_ctrl.sv
// Windowed CPI sampling controller: accumulates per-cycle stall categories over a
// programmable window, snapshots them into one shadow buffer and streams 7 words out.
module ibex_cpi_sample_ctrl #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned WIN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [WIN_W-1:0] win_len_i,
  input  logic             inhibit_i,
  input  logic             ev_base_i,
  input  logic             ev_icache_i,
  input  logic             ev_bpred_i,
  input  logic             ev_dcache_i,
  input  logic             ev_ex_i,
  input  logic             ev_dep_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CNT_W-1:0] out_data_o,
  output logic [2:0]       out_idx_o,
  output logic             out_last_o,
  output logic             busy_o,
  output logic             overrun_o
);

  localparam int unsigned NW = 7;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e           state_q, state_d;
  logic [WIN_W-1:0] win_len_q, win_len_d;
  logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
  logic [WIN_W-1:0] win_cnt_inc;
  logic [CNT_W-1:0] cnt_q    [NW];
  logic [CNT_W-1:0] cnt_d    [NW];
  logic [CNT_W-1:0] cnt_inc  [NW];
  logic [CNT_W-1:0] shadow_q [NW];
  logic [CNT_W-1:0] shadow_d [NW];
  logic             shadow_full_q, shadow_full_d;
  logic [2:0]       idx_q, idx_d;
  logic             overrun_q, overrun_d;
  logic [NW-1:0]    inc;
  logic             hs, last_hs, shadow_free, win_end, snap;

  // Slot 0 is the cycle count; slots 1..6 follow the stream word order.
  always_comb begin
    inc[0] = 1'b1;
    inc[1] = ev_base_i   & ~inhibit_i;
    inc[2] = ev_icache_i & ~inhibit_i;
    inc[3] = ev_bpred_i  & ~inhibit_i;
    inc[4] = ev_dcache_i & ~inhibit_i;
    inc[5] = ev_ex_i     & ~inhibit_i;
    inc[6] = ev_dep_i    & ~inhibit_i;
    for (int i = 0; i < NW; i++) begin
      cnt_inc[i] = (inc[i] && (cnt_q[i] != CNT_MAX)) ? cnt_q[i] + 1'b1 : cnt_q[i];
    end
  end

  assign win_cnt_inc = win_cnt_q + 1'b1;
  assign win_end     = (win_cnt_inc == win_len_q);
  assign snap        = (state_q == RUN) & (win_end | stop_i);
  assign hs          = shadow_full_q & out_ready_i;
  assign last_hs     = hs & (idx_q == 3'd6);
  // Freeing on the final handshake lets a new snapshot land back-to-back.
  assign shadow_free = ~shadow_full_q | last_hs;

  always_comb begin
    state_d       = state_q;
    win_len_d     = win_len_q;
    win_cnt_d     = win_cnt_q;
    shadow_full_d = shadow_full_q;
    idx_d         = idx_q;
    overrun_d     = overrun_q;
    for (int i = 0; i < NW; i++) begin
      cnt_d[i]    = cnt_q[i];
      shadow_d[i] = shadow_q[i];
    end

    if (hs) begin
      if (idx_q == 3'd6) begin
        shadow_full_d = 1'b0;
        idx_d         = 3'd0;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = RUN;
          win_len_d = (win_len_i == '0) ? WIN_W'(1) : win_len_i;
          win_cnt_d = '0;
          overrun_d = 1'b0;
          for (int i = 0; i < NW; i++) cnt_d[i] = '0;
        end
      end
      RUN: begin
        win_cnt_d = win_cnt_inc;
        for (int i = 0; i < NW; i++) cnt_d[i] = cnt_inc[i];
        if (snap) begin
          if (shadow_free) begin
            shadow_full_d = 1'b1;
            idx_d         = 3'd0;
            for (int i = 0; i < NW; i++) shadow_d[i] = cnt_inc[i];
          end else begin
            overrun_d = 1'b1;
          end
          win_cnt_d = '0;
          for (int i = 0; i < NW; i++) cnt_d[i] = '0;
          if (stop_i) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      win_len_q     <= '0;
      win_cnt_q     <= '0;
      shadow_full_q <= 1'b0;
      idx_q         <= 3'd0;
      overrun_q     <= 1'b0;
      for (int i = 0; i < NW; i++) begin
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      win_len_q     <= win_len_d;
      win_cnt_q     <= win_cnt_d;
      shadow_full_q <= shadow_full_d;
      idx_q         <= idx_d;
      overrun_q     <= overrun_d;
      for (int i = 0; i < NW; i++) begin
        cnt_q[i]    <= cnt_d[i];
        shadow_q[i] <= shadow_d[i];
      end
    end
  end

  always_comb begin
    out_data_o = '0;
    for (int i = 0; i < NW; i++) begin
      if (idx_q == 3'(i)) out_data_o = shadow_q[i];
    end
  end

  assign out_valid_o = shadow_full_q;
  assign out_idx_o   = idx_q;
  assign out_last_o  = shadow_full_q & (idx_q == 3'd6);
  assign busy_o      = (state_q == RUN) | shadow_full_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_ibex_cpi_sample_ctrl.sv
// Randomized and directed bench for ibex_cpi_sample_ctrl, checked against a
// cycle-level behavioural model of windows, bursts and overruns.
module tb_ibex_cpi_sample_ctrl;

  localparam int CNT_W = 6;
  localparam int WIN_W = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             start;
  logic             stop;
  logic [WIN_W-1:0] winLen;
  logic             inhibit;
  logic [5:0]       ev;
  logic             outValid;
  logic             outReady;
  logic [CNT_W-1:0] outData;
  logic [2:0]       outIdx;
  logic             outLast;
  logic             busy;
  logic             overrun;

  ibex_cpi_sample_ctrl #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .stop_i      (stop),
    .win_len_i   (winLen),
    .inhibit_i   (inhibit),
    .ev_base_i   (ev[0]),
    .ev_icache_i (ev[1]),
    .ev_bpred_i  (ev[2]),
    .ev_dcache_i (ev[3]),
    .ev_ex_i     (ev[4]),
    .ev_dep_i    (ev[5]),
    .out_valid_o (outValid),
    .out_ready_i (outReady),
    .out_data_o  (outData),
    .out_idx_o   (outIdx),
    .out_last_o  (outLast),
    .busy_o      (busy),
    .overrun_o   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;

  // Model: live counts (cycles, then the six categories), the held burst and
  // how many of its words are still waiting to be accepted.
  bit mRun;
  int mLen;
  int mPos;
  int mLive[7];
  int mShadow[7];
  int mRem;
  bit mOvr;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nTests++;
    if (obs !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("valid", outValid, mRem > 0);
    checkOutput("busy", busy, mRun || (mRem > 0));
    checkOutput("overrun", overrun, mOvr);
    if (mRem > 0) begin
      checkOutput("idx", outIdx, 7 - mRem);
      checkOutput("data", outData, mShadow[7 - mRem]);
      checkOutput("last", outLast, mRem == 1);
    end else begin
      checkOutput("last_idle", outLast, 0);
    end
  endtask

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic modelStep(input bit st, input bit sp, input int wl, input bit inh,
                           input bit [5:0] e, input bit rdy, input bit rs);
    bit hs;
    bit free;
    hs   = (mRem > 0) && rdy;
    free = (mRem == 0) || (mRem == 1 && hs);
    if (hs) mRem--;
    if (rs) begin
      mRun = 0; mLen = 0; mPos = 0; mRem = 0; mOvr = 0;
      for (int k = 0; k < 7; k++) begin mLive[k] = 0; mShadow[k] = 0; end
      return;
    end
    if (!mRun) begin
      if (st) begin
        mRun = 1;
        mLen = (wl == 0) ? 1 : wl;
        mPos = 0;
        mOvr = 0;
        for (int k = 0; k < 7; k++) mLive[k] = 0;
      end
    end else begin
      mLive[0] = sat(mLive[0]);
      for (int k = 0; k < 6; k++) if (e[k] && !inh) mLive[k + 1] = sat(mLive[k + 1]);
      mPos++;
      if (mPos == mLen || sp) begin
        if (free) begin
          for (int k = 0; k < 7; k++) mShadow[k] = mLive[k];
          mRem = 7;
        end else begin
          mOvr = 1;
        end
        for (int k = 0; k < 7; k++) mLive[k] = 0;
        mPos = 0;
        if (sp) mRun = 0;
      end
    end
  endtask

  task automatic applyStimulus(input bit st, input bit sp, input int wl, input bit inh,
                               input bit [5:0] e, input bit rdy, input bit rs);
    @(negedge clk);
    checkAll();
    start    = st;
    stop     = sp;
    winLen   = WIN_W'(wl);
    inhibit  = inh;
    ev       = e;
    outReady = rdy;
    rst      = rs;
    modelStep(st, sp, wl, inh, e, rdy, rs);
  endtask

  task automatic runFor(input int n, input bit [5:0] e, input bit inh, input bit rdy);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, inh, e, rdy, 0);
  endtask

  task automatic stopAndDrain();
    applyStimulus(0, 1, 0, 0, 6'h00, 1, 0);
    runFor(16, 6'h00, 0, 1);
  endtask

  initial begin
    int guard;
    rst = 1; start = 0; stop = 0; winLen = '0; inhibit = 0; ev = '0; outReady = 0;
    mRun = 0; mLen = 0; mPos = 0; mRem = 0; mOvr = 0;
    for (int k = 0; k < 7; k++) begin mLive[k] = 0; mShadow[k] = 0; end
    repeat (2) @(posedge clk);
    applyStimulus(0, 0, 0, 0, 6'h00, 0, 0);

    // Back-to-back windows of base events with the sink always ready.
    applyStimulus(1, 0, 4, 0, 6'h01, 1, 0);
    runFor(24, 6'h01, 0, 1);
    stopAndDrain();

    // Sink stalls while the first word is presented.
    applyStimulus(1, 0, 3, 0, 6'h02, 0, 0);
    runFor(8, 6'h02, 0, 0);
    runFor(10, 6'h02, 0, 1);
    stopAndDrain();

    // Held snapshot forces an overrun; a later start clears it.
    applyStimulus(1, 0, 2, 0, 6'h01, 0, 0);
    runFor(6, 6'h01, 0, 0);
    applyStimulus(0, 1, 0, 0, 6'h01, 0, 0);
    runFor(9, 6'h00, 0, 1);
    applyStimulus(1, 0, 10, 0, 6'h20, 1, 0);

    // Early stop on the third counted cycle.
    runFor(2, 6'h20, 0, 1);
    applyStimulus(0, 1, 0, 0, 6'h20, 1, 0);
    runFor(10, 6'h00, 0, 1);

    // Inhibit for three cycles mid-window.
    applyStimulus(1, 0, 8, 0, 6'h08, 1, 0);
    runFor(3, 6'h08, 0, 1);
    runFor(3, 6'h08, 1, 1);
    runFor(10, 6'h08, 0, 1);
    stopAndDrain();

    // Saturation, then reset while word 3 is on the bus.
    applyStimulus(1, 0, 80, 0, 6'h01, 1, 0);
    guard = 0;
    while (mRem != 4 && guard < 300) begin
      applyStimulus(0, 0, 0, 0, 6'h01, 1, 0);
      guard++;
    end
    checkOutput("reset_wait", guard < 300, 1);
    checkOutput("sat_cycles", mShadow[0], CMAX);
    applyStimulus(0, 0, 0, 0, 6'h01, 1, 1);
    applyStimulus(0, 0, 0, 0, 6'h00, 1, 0);
    checkOutput("rst_valid", outValid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_overrun", overrun, 0);

    // Random traffic, including start/stop in the wrong state and window length 0.
    for (int n = 0; n < 4000; n++) begin
      bit st, sp, inh, rdy, rs;
      int wl;
      st  = ($urandom_range(0, 19) == 0);
      sp  = ($urandom_range(0, 29) == 0);
      inh = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 9) < 7);
      rs  = ($urandom_range(0, 799) == 0);
      wl  = ($urandom_range(0, 15) == 0) ? $urandom_range(60, 90) : $urandom_range(0, 12);
      applyStimulus(st, sp, wl, inh, 6'($urandom), rdy, rs);
    end

    @(negedge clk);
    checkAll();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
